// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, execute-op kinds and program ROM geometry.
package cpu_pkg;

  localparam int ROM_DEPTH = 256;
  localparam int INSTR_W   = 24;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_DELAY = 8'h10;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [2:0] KIND_MOV = 3'd0;
  localparam logic [2:0] KIND_ADD = 3'd1;
  localparam logic [2:0] KIND_SUB = 3'd2;
  localparam logic [2:0] KIND_AND = 3'd3;
  localparam logic [2:0] KIND_OR  = 3'd4;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder; shared with the trace/disassembly tooling.
module opcode_classify
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_alu,
  output logic [2:0] kind,
  output logic       is_nop,
  output logic       is_delay,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_alu     = 1'b0;
    kind       = KIND_MOV;
    is_nop     = 1'b0;
    is_delay   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:   is_nop   = 1'b1;
      OP_MOV:   begin is_alu = 1'b1; kind = KIND_MOV; end
      OP_ADD:   begin is_alu = 1'b1; kind = KIND_ADD; end
      OP_SUB:   begin is_alu = 1'b1; kind = KIND_SUB; end
      OP_AND:   begin is_alu = 1'b1; kind = KIND_AND; end
      OP_OR:    begin is_alu = 1'b1; kind = KIND_OR;  end
      OP_DELAY: is_delay = 1'b1;
      OP_HALT:  is_halt  = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// Fetch/decode stage: walks the program ROM, issues ALU/MOV ops to execute,
// and absorbs NOP/DELAY/HALT locally.
module instr_decode
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               exec_ready,
  output logic               rom_enable,
  output logic               op_valid,
  output logic [2:0]         op_kind,
  output logic [2:0]         op_rd,
  output logic [2:0]         op_rs,
  output logic [7:0]         op_imm,
  output logic [7:0]         fetch_idx,
  output logic               halted,
  output logic               illegal
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [7:0] LAST_LINE = 8'(ROM_DEPTH - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt;
  logic       retire, end_of_rom;

  logic       c_alu, c_nop, c_delay, c_halt, c_illegal;
  logic [2:0] c_kind;

  // Only the low three bits of operand A name a register.
  logic unused_opa;
  assign unused_opa = ^instr[15:11];

  opcode_classify u_cls (
    .opcode     (instr[23:16]),
    .is_alu     (c_alu),
    .kind       (c_kind),
    .is_nop     (c_nop),
    .is_delay   (c_delay),
    .is_halt    (c_halt),
    .is_illegal (c_illegal)
  );

  assign end_of_rom = (fetch_idx == LAST_LINE);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (c_halt)                           state_nxt = S_HALT;
        else if (c_alu)                       state_nxt = S_ISSUE;
        else if (c_delay && instr[7:0] != '0) state_nxt = S_DELAY;
        else                                  retire    = 1'b1;
      end
      S_ISSUE: if (exec_ready) begin retire = 1'b1; state_nxt = S_FETCH; end
      S_DELAY: if (cnt == 8'd1) begin retire = 1'b1; state_nxt = S_FETCH; end
      default: state_nxt = S_HALT;
    endcase
    // The last ROM line retires into HALT instead of advancing the address.
    if (retire && end_of_rom) state_nxt = S_HALT;
  end

  assign rom_enable = !rst && retire && !end_of_rom;
  assign op_valid   = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      cnt       <= '0;
      fetch_idx <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      op_kind   <= '0;
      op_rd     <= '0;
      op_rs     <= '0;
      op_imm    <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_HALT && state_nxt == S_HALT) halted <= 1'b1;
      if (rom_enable) fetch_idx <= fetch_idx + 8'd1;
      if (state == S_FETCH) begin
        op_kind <= c_kind;
        op_rd   <= instr[10:8];
        op_rs   <= instr[2:0];
        op_imm  <= instr[7:0];
        if (c_illegal) illegal <= 1'b1;
        if (state_nxt == S_DELAY) cnt <= instr[7:0];
      end else if (state == S_DELAY) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: behavioural ROM, scoreboard of issued ops, table vectors
// and hand-written sequences for halt, end-of-ROM and reset during issue.
module tb_instr_decode;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] instr;
  logic        exec_ready;
  logic        rom_enable, op_valid, halted, illegal;
  logic [2:0]  op_kind, op_rd, op_rs;
  logic [7:0]  op_imm, fetch_idx;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .exec_ready(exec_ready),
    .rom_enable(rom_enable), .op_valid(op_valid), .op_kind(op_kind),
    .op_rd(op_rd), .op_rs(op_rs), .op_imm(op_imm), .fetch_idx(fetch_idx),
    .halted(halted), .illegal(illegal)
  );

  // Program ROM: address resets with rst, advances on rom_enable.
  logic [23:0] rom [256];
  logic [7:0]  rom_addr;
  always_ff @(posedge clk) begin
    if (rst) rom_addr <= '0;
    else if (rom_enable) rom_addr <= rom_addr + 8'd1;
  end
  assign instr = rom[rom_addr];

  int n_vec = 0;
  int n_err = 0;
  int xfers = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] kind;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } op_t;
  op_t exp_q[$];

  // Transfer monitor: inputs are driven at negedge, so mid-low-phase is stable.
  always begin
    @(negedge clk);
    #3;
    if (!rst && op_valid && exec_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 1, 0);
      end else begin
        op_t e;
        e = exp_q.pop_front();
        chk("xfer_kind", op_kind, e.kind);
        chk("xfer_rd", op_rd, e.rd);
        chk("xfer_rs", op_rs, e.rs);
        chk("xfer_imm", op_imm, e.imm);
      end
    end
  end

  typedef struct {
    logic [23:0] instr;
    int          stall;
    bit          is_op;
    logic [2:0]  kind;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [7:0]  imm;
    int          retire_c;
    bit          illg;
  } vec_t;
  vec_t vt[11];

  // Returns at the negedge of cycle 0 (FETCH of line 0) with rst released.
  task automatic do_reset();
    rst = 1'b1;
    exec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_rom(input logic [23:0] l0, input logic [23:0] l1);
    for (int a = 0; a < 256; a++) rom[a] = 24'h0;
    rom[0] = l0;
    rom[1] = l1;
  endtask

  initial begin
    //            instr        stall op kind rd rs imm    retire illegal
    vt[0]  = '{24'h01032A, 0, 1, 3'd0, 3'd3, 3'd2, 8'h2A, 1, 0};
    vt[1]  = '{24'h020102, 3, 1, 3'd1, 3'd1, 3'd2, 8'h02, 4, 0};
    vt[2]  = '{24'h03FDF6, 1, 1, 3'd2, 3'd5, 3'd6, 8'hF6, 2, 0};
    vt[3]  = '{24'h040704, 0, 1, 3'd3, 3'd7, 3'd4, 8'h04, 1, 0};
    vt[4]  = '{24'h050000, 2, 1, 3'd4, 3'd0, 3'd0, 8'h00, 3, 0};
    vt[5]  = '{24'h000000, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0};
    vt[6]  = '{24'h100005, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 5, 0};
    vt[7]  = '{24'h100000, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0};
    vt[8]  = '{24'h7E0000, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 1};
    vt[9]  = '{24'h10AB01, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0};
    vt[10] = '{24'h061234, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 1};

    // Reset state, sampled while rst is still held.
    load_rom(24'h0, 24'h0);
    rst = 1'b1;
    exec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rom_enable", rom_enable, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_kind", op_kind, 0);
    chk("rst_op_rd", op_rd, 0);
    chk("rst_op_rs", op_rs, 0);
    chk("rst_op_imm", op_imm, 0);
    chk("rst_fetch_idx", fetch_idx, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);

    // Single-instruction vectors: line 0 under test, NOPs after it.
    foreach (vt[i]) begin
      vec_t v;
      int   seen, nvalid;
      v = vt[i];
      load_rom(v.instr, 24'h0);
      if (v.is_op) exp_q.push_back('{v.kind, v.rd, v.rs, v.imm});
      do_reset();
      seen = -1;
      nvalid = 0;
      for (int c = 0; c < 40 && seen < 0; c++) begin
        exec_ready = (c > v.stall);
        #1;
        if (op_valid) begin
          nvalid++;
          chk($sformatf("v%0d_kind", i), op_kind, v.kind);
          chk($sformatf("v%0d_rd", i), op_rd, v.rd);
          chk($sformatf("v%0d_rs", i), op_rs, v.rs);
          chk($sformatf("v%0d_imm", i), op_imm, v.imm);
        end
        if (rom_enable) seen = c;
        @(negedge clk);
      end
      #1;
      chk($sformatf("v%0d_retire_cycle", i), seen, v.retire_c);
      chk($sformatf("v%0d_valid_cycles", i), nvalid, v.is_op ? v.stall + 1 : 0);
      chk($sformatf("v%0d_fetch_idx", i), fetch_idx, 1);
      chk($sformatf("v%0d_illegal", i), illegal, v.illg);
      chk($sformatf("v%0d_halted", i), halted, 0);
    end

    // Illegal opcode then HALT.
    begin
      int activity = 0;
      load_rom(24'h7E0000, 24'hFF0000);
      do_reset();
      #1;
      chk("ih_illegal_c0", illegal, 0);
      @(negedge clk); #1;
      chk("ih_illegal_c1", illegal, 1);
      chk("ih_halted_c1", halted, 0);
      @(negedge clk); #1;
      chk("ih_halted_c2", halted, 1);
      chk("ih_fetch_idx_c2", fetch_idx, 1);
      exec_ready = 1'b1;
      repeat (22) begin
        @(negedge clk); #1;
        if (rom_enable || op_valid) activity++;
      end
      chk("ih_activity", activity, 0);
      chk("ih_fetch_idx_end", fetch_idx, 1);
      chk("ih_halted_end", halted, 1);
    end

    // End of ROM: 256 NOPs.
    begin
      int pulses = 0;
      load_rom(24'h0, 24'h0);
      do_reset();
      for (int c = 0; c < 256; c++) begin
        #1;
        if (c == 255) begin
          chk("eor_fetch_idx_c255", fetch_idx, 8'hFF);
          chk("eor_rom_enable_c255", rom_enable, 0);
        end
        if (rom_enable) pulses++;
        @(negedge clk);
      end
      #1;
      chk("eor_pulses", pulses, 255);
      chk("eor_halted", halted, 1);
      chk("eor_fetch_idx", fetch_idx, 8'hFF);
      repeat (5) @(negedge clk);
      #1;
      chk("eor_fetch_idx_hold", fetch_idx, 8'hFF);
      chk("eor_rom_enable_hold", rom_enable, 0);
    end

    // Reset asserted during ISSUE with exec_ready high.
    begin
      int xb;
      load_rom(24'h010509, 24'h0);
      xb = xfers;
      do_reset();
      @(negedge clk);
      rst = 1'b1;
      exec_ready = 1'b1;
      #1;
      chk("ri_valid_before", op_valid, 1);
      @(negedge clk); #1;
      chk("ri_valid_rst", op_valid, 0);
      chk("ri_fetch_idx_rst", fetch_idx, 0);
      chk("ri_rd_rst", op_rd, 0);
      chk("ri_imm_rst", op_imm, 0);
      chk("ri_no_xfer", xfers, xb);
      exp_q.push_back('{KIND_MOV, 3'd5, 3'd1, 8'h09});
      rst = 1'b0;
      @(negedge clk); #1;
      chk("ri_valid_again", op_valid, 1);
      chk("ri_rd_again", op_rd, 5);
      @(negedge clk); #1;
      chk("ri_fetch_idx_after", fetch_idx, 1);
      chk("ri_one_xfer", xfers, xb + 1);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Fetch/decode stage directly downstream of the 256×24-bit program ROM. Each cycle it samples the ROM's combinational 24-bit instruction word. It decodes opcode and operands, issues ALU/MOV operations to the execute stage over a valid/ready handshake, and absorbs NOP/DELAY/HALT locally. It owns the ROM's `enable` input and keeps an 8-bit mirror of the ROM address.

## Interface
Parameters:
- none (the 24-bit word, 8-bit address and opcode map are fixed)

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. Shared with the ROM so both return to address 0 together.
- `instr` in 24: ROM data. Fields: [23:16] opcode, [15:8] operand A, [7:0] operand B.
- `exec_ready` in 1: execute stage accepts the current op.
- `rom_enable` out 1: one-cycle pulse that advances the ROM address.
- `op_valid` out 1: issued op is present.
- `op_kind` out 3: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR.
- `op_rd` out 3: destination register = A[2:0].
- `op_rs` out 3: source register = B[2:0].
- `op_imm` out 8: immediate = B.
- `fetch_idx` out 8: mirror of the ROM address.
- `halted` out 1: sticky; set by HALT or end of ROM.
- `illegal` out 1: sticky; set by an undefined opcode.

## Operation
- Opcodes:
  - 0x00 NOP
  - 0x01 MOV rd,imm
  - 0x02 ADD rd,rs
  - 0x03 SUB
  - 0x04 AND
  - 0x05 OR
  - 0x10 DELAY n (n = B)
  - 0xFF HALT
  - All other opcodes are illegal. They set `illegal` and execute as NOP.
- FSM states: FETCH, ISSUE, DELAY, HALT. Reset state is FETCH.
- **FETCH:** latch `instr` into the instruction register `ir`, then branch on opcode:
  - ALU/MOV → ISSUE.
  - NOP, illegal, or DELAY with n=0 → retire this cycle, stay in FETCH.
  - DELAY with n>0 → load the counter with n, go to DELAY.
  - HALT → HALT, set `halted`. No retire.
- **ISSUE:**
  - `op_valid`=1. `op_*` are driven from `ir` and held stable until the handshake.
  - On `exec_ready`=1: retire, go to FETCH.
- **DELAY:**
  - The counter decrements each cycle.
  - In the cycle where counter==1: retire, go to FETCH.
- **HALT:** absorbing. Only `rst` exits. `rom_enable`=0 and `op_valid`=0.
- **Retire:**
  - Normal case: `rom_enable`=1 (Mealy, same cycle), and `fetch_idx` increments at that edge.
  - End of ROM: if `fetch_idx`==0xFF at retire, `rom_enable` stays 0, the FSM goes to HALT, and `halted` is set. `fetch_idx` never wraps.
- **Operand fields:** upper operand bits A[7:3] and B[7:3] are ignored for register fields.

## Timing
- **Reset values:**
  - `rom_enable`=0, `op_valid`=0, `op_kind`/`op_rd`/`op_rs`/`op_imm`=0.
  - `fetch_idx`=0, `halted`=0, `illegal`=0.
  - State = FETCH, counter = 0.
- **First cycle after reset:** the FETCH of ROM line 0. ROM data for a new address is valid the cycle after the `rom_enable` pulse.
- **Latencies (cycles per instruction):**
  - ALU/MOV with `exec_ready` tied high: 2 (FETCH, ISSUE).
  - Each cycle `exec_ready` is low adds 1.
  - NOP/illegal: 1. DELAY n: 1+n. HALT: terminal.
- **Handshake:** transfer occurs on the edge where `op_valid`&&`exec_ready`. `op_valid` deasserts the following cycle (FETCH). It is never asserted on consecutive cycles.
- **`exec_ready` outside ISSUE:** ignored.
- **`rst` mid-operation:** takes priority in any state, including ISSUE with `exec_ready`=1. The pending op is dropped, and all outputs take reset values at the next edge.

## Structure
- Shared package `cpu_pkg`:
  - Opcode localparams (OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DELAY, OP_HALT).
  - `op_kind` encodings.
  - ROM_DEPTH=256, INSTR_W=24.
- State encoding stays local to the block.
- One natural sub-module: `opcode_classify`. It is purely combinational: opcode → {is_alu, kind, is_nop, is_delay, is_halt, is_illegal}. It is reused by a future disassembler/trace monitor.

## Test plan
- **Basic MOV:** ROM line 0 = 0x01_03_2A, `exec_ready`=1.
  - `op_valid`=1 in cycle 1 with `op_kind`=0, `op_rd`=3, `op_imm`=0x2A.
  - `rom_enable`=1 in cycle 1; `fetch_idx`=1 in cycle 2.
- **Backpressure:** ADD 0x02_01_02 with `exec_ready` low for 3 cycles.
  - `op_valid` is held 4 cycles with `op_kind`=1, `op_rd`=1, `op_rs`=2, all stable.
  - Exactly one `rom_enable` pulse.
- **Delay and NOP:** DELAY 0x10_00_05 then NOP.
  - 6 cycles pass before FETCH of line 1, with no `op_valid`.
  - The NOP retires in 1 cycle; DELAY with n=0 behaves identically to NOP.
- **Illegal and HALT:** line 0 = 0x7E_00_00, line 1 = 0xFF_00_00.
  - `illegal`=1 from cycle 1.
  - `halted`=1 from cycle 2, `fetch_idx` stays 1, `rom_enable` stays 0 for 20+ cycles.
- **End of ROM:** 256 NOPs.
  - `fetch_idx` reaches 0xFF.
  - The retire of line 255 sets `halted` with no `rom_enable`.
- **Reset mid-issue:** assert `rst` during ISSUE with `exec_ready`=1.
  - No transfer counted.
  - After release, `fetch_idx`=0 and line 0 is re-issued.
